// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness tracking datapath: rate width,
// the high-activity threshold used downstream, and the meter FSM states.
package fitness_pkg;

  localparam int PPM_W        = 10;
  localparam int HIGH_ACT_PPM = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// Brings the asynchronous step pulse into the clock domain and turns each
// rising edge into a single-cycle registered hit strobe.
// Optional input filtering is enabled with the PULSE_DEBOUNCE_EN macro.
module pulse_sync_edge #(
`ifdef PULSE_DEBOUNCE_EN
  parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pulse_i,
  output logic hit_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic hit_q;
  logic level_w;

  // Two-flop synchronizer for the raw pulse input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync2_q ^ (sync1_q ^ sync2_q);
    end
  end

`ifdef PULSE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  // Debounce: a new level is accepted only after it has held for DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      cnt_q   <= '0;
      level_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level_w = level_q;
`else
  assign level_w = sync2_q;
`endif

  // Rising-edge detector on the (optionally debounced) level, registered strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      prev_q <= level_w;
      hit_q  <= level_w & ~prev_q;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts step pulses per one-second window and publishes the last window's
// count plus a moving average over the last 2^AVG_LOG2 windows.
// Optional input debounce is enabled with the PULSE_DEBOUNCE_EN macro.
module pulse_rate_meter #(
  parameter int PPM_W    = fitness_pkg::PPM_W,
  parameter int AVG_LOG2 = 2
`ifdef PULSE_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sec_tick,
  input  logic             pulse_in,
  output logic [PPM_W-1:0] ppm,
  output logic [PPM_W-1:0] ppm_avg,
  output logic             ppm_valid,
  output logic             avg_ready
);

  import fitness_pkg::*;

  localparam int                DEPTH     = 1 << AVG_LOG2;
  localparam int                SUM_W     = PPM_W + AVG_LOG2;
  localparam logic [PPM_W-1:0]  CNT_MAX   = '1;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0] FILL_LAST = FILL_FULL - 1'b1;

  logic                hit;
  state_e              state_q;
  logic [PPM_W-1:0]    win_cnt_q;
  logic [PPM_W-1:0]    win_cnt_d;
  logic [PPM_W-1:0]    ring_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [AVG_LOG2:0]   fill_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [PPM_W-1:0]    ppm_q;
  logic [PPM_W-1:0]    ppm_avg_q;
  logic                valid_q;
  logic                avg_ready_q;

  pulse_sync_edge #(
`ifdef PULSE_DEBOUNCE_EN
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
`endif
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .pulse_i (pulse_in),
    .hit_o   (hit)
  );

  // Saturating window count including this cycle's hit, and the running sum
  // after replacing the oldest ring entry with that count
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (hit && (win_cnt_q != CNT_MAX)) begin
      win_cnt_d = win_cnt_q + 1'b1;
    end
    sum_d = sum_q + SUM_W'(win_cnt_d) - SUM_W'(ring_q[wr_ptr_q]);
  end

  // Measurement FSM: arm on the first tick, count hits, publish on each tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      ppm_q       <= '0;
      ppm_avg_q   <= '0;
      valid_q     <= 1'b0;
      avg_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
          end
        end
        ARM, RUN: begin
          if (!start) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            avg_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              ring_q[i] <= '0;
            end
          end else if (state_q == ARM) begin
            if (sec_tick) begin
              win_cnt_q <= '0;
              state_q   <= RUN;
            end
          end else if (sec_tick) begin
            ppm_q            <= win_cnt_d;
            ring_q[wr_ptr_q] <= win_cnt_d;
            sum_q            <= sum_d;
            ppm_avg_q        <= sum_d[SUM_W-1:AVG_LOG2];
            valid_q          <= 1'b1;
            win_cnt_q        <= '0;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
              fill_q <= fill_q + 1'b1;
            end
            if (fill_q == FILL_LAST) begin
              avg_ready_q <= 1'b1;
            end
          end else begin
            win_cnt_q <= win_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ppm       = ppm_q;
  assign ppm_avg   = ppm_avg_q;
  assign ppm_valid = valid_q;
  assign avg_ready = avg_ready_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed self-checking bench for pulse_rate_meter.
// Build with PULSE_DEBOUNCE_EN defined to also exercise the glitch filter.
module tb_pulse_rate_meter;

`ifdef PULSE_DEBOUNCE_EN
  localparam int PW      = 20;
  localparam int HIT_LAT = 19;
`else
  localparam int PW      = 2;
  localparam int HIT_LAT = 3;
`endif

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       sec_tick;
  logic       pulse_in;
  logic [9:0] ppm;
  logic [9:0] ppm_avg;
  logic       ppm_valid;
  logic       avg_ready;

  int checks;
  int passes;

  pulse_rate_meter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sec_tick  (sec_tick),
    .pulse_in  (pulse_in),
    .ppm       (ppm),
    .ppm_avg   (ppm_avg),
    .ppm_valid (ppm_valid),
    .avg_ready (avg_ready)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n full pulses and let the last hit drain through the pipeline
  task automatic applyPulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      waitCycles(PW);
      pulse_in = 1'b0;
      waitCycles(PW);
    end
    waitCycles(HIT_LAT + 3);
  endtask

  // One-cycle sec_tick; returns at the negedge right after the update edge
  task automatic applyTick;
    sec_tick = 1'b1;
    waitCycles(1);
    sec_tick = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    waitCycles(2);
    checks++; if (ppm !== 10'd0) $display("[TB] FAIL reset_ppm: got %0d expected 0", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd0) $display("[TB] FAIL reset_avg: got %0d expected 0", ppm_avg); else passes++;
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", ppm_valid); else passes++;
    checks++; if (avg_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %0b expected 0", avg_ready); else passes++;
    reset_n = 1'b1;
    waitCycles(2);
    seen = 0;
    for (int t = 0; t < 2; t++) begin
      sec_tick = 1'b1;
      waitCycles(1);
      sec_tick = 1'b0;
      if (ppm_valid) seen++;
      waitCycles(1);
      if (ppm_valid) seen++;
    end
    checks++; if (seen !== 0) $display("[TB] FAIL idle_tick_valid: got %0d strobes expected 0", seen); else passes++;
  endtask

  task automatic test_single_window;
    start = 1'b1;
    waitCycles(1);
    applyTick();
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL arm_tick_valid: got %0b expected 0", ppm_valid); else passes++;
    applyPulses(70);
    applyTick();
    checks++; if (ppm_valid !== 1'b1) $display("[TB] FAIL single_valid: got %0b expected 1", ppm_valid); else passes++;
    checks++; if (ppm !== 10'd70) $display("[TB] FAIL single_ppm: got %0d expected 70", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd17) $display("[TB] FAIL single_avg: got %0d expected 17", ppm_avg); else passes++;
    checks++; if (avg_ready !== 1'b0) $display("[TB] FAIL single_ready: got %0b expected 0", avg_ready); else passes++;
    waitCycles(1);
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL single_valid_width: got %0b expected 0", ppm_valid); else passes++;
  endtask

  task automatic test_average;
    logic [9:0] expAvg;
    start = 1'b0;
    waitCycles(2);
    start = 1'b1;
    waitCycles(1);
    applyTick();
    for (int w = 0; w < 4; w++) begin
      applyPulses(64);
      applyTick();
      expAvg = 10'(16 * (w + 1));
      checks++; if (ppm !== 10'd64) $display("[TB] FAIL avg_ppm_%0d: got %0d expected 64", w, ppm); else passes++;
      checks++; if (ppm_avg !== expAvg) $display("[TB] FAIL avg_value_%0d: got %0d expected %0d", w, ppm_avg, expAvg); else passes++;
      checks++; if (avg_ready !== (w == 3)) $display("[TB] FAIL avg_ready_%0d: got %0b expected %0b", w, avg_ready, (w == 3)); else passes++;
    end
    applyPulses(0);
    applyTick();
    checks++; if (ppm !== 10'd0) $display("[TB] FAIL avg_zero_ppm: got %0d expected 0", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd48) $display("[TB] FAIL avg_zero_avg: got %0d expected 48", ppm_avg); else passes++;
    checks++; if (avg_ready !== 1'b1) $display("[TB] FAIL avg_zero_ready: got %0b expected 1", avg_ready); else passes++;
  endtask

  task automatic test_saturation;
    applyPulses(1100);
    applyTick();
    checks++; if (ppm !== 10'd1023) $display("[TB] FAIL sat_ppm: got %0d expected 1023", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd287) $display("[TB] FAIL sat_avg: got %0d expected 287", ppm_avg); else passes++;
  endtask

  task automatic test_coincident;
    applyPulses(10);
    pulse_in = 1'b1;
    waitCycles(HIT_LAT);
    applyTick();
    checks++; if (ppm !== 10'd11) $display("[TB] FAIL coinc_ppm: got %0d expected 11", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd274) $display("[TB] FAIL coinc_avg: got %0d expected 274", ppm_avg); else passes++;
    pulse_in = 1'b0;
    waitCycles(PW + HIT_LAT);
  endtask

  task automatic test_reset_mid_run;
    int seen;
    checks++; if (avg_ready !== 1'b1) $display("[TB] FAIL pre_reset_ready: got %0b expected 1", avg_ready); else passes++;
    applyPulses(5);
    reset_n = 1'b0;
    #1;
    checks++; if (ppm !== 10'd0) $display("[TB] FAIL mid_reset_ppm: got %0d expected 0", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd0) $display("[TB] FAIL mid_reset_avg: got %0d expected 0", ppm_avg); else passes++;
    checks++; if (avg_ready !== 1'b0) $display("[TB] FAIL mid_reset_ready: got %0b expected 0", avg_ready); else passes++;
    start = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(1);
    seen = 0;
    for (int t = 0; t < 3; t++) begin
      sec_tick = 1'b1;
      waitCycles(1);
      sec_tick = 1'b0;
      if (ppm_valid) seen++;
      waitCycles(1);
      if (ppm_valid) seen++;
    end
    checks++; if (seen !== 0) $display("[TB] FAIL post_reset_valid: got %0d strobes expected 0", seen); else passes++;
  endtask

  task automatic test_start_drop;
    start = 1'b1;
    waitCycles(1);
    applyTick();
    applyPulses(12);
    applyTick();
    checks++; if (ppm !== 10'd12) $display("[TB] FAIL drop_first_ppm: got %0d expected 12", ppm); else passes++;
    applyPulses(30);
    start = 1'b0;
    waitCycles(2);
    applyTick();
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL drop_valid: got %0b expected 0", ppm_valid); else passes++;
    checks++; if (ppm !== 10'd12) $display("[TB] FAIL drop_hold_ppm: got %0d expected 12", ppm); else passes++;
    start = 1'b1;
    waitCycles(1);
    applyPulses(5);
    applyTick();
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL rearm_valid: got %0b expected 0", ppm_valid); else passes++;
    applyPulses(7);
    applyTick();
    checks++; if (ppm !== 10'd7) $display("[TB] FAIL rearm_ppm: got %0d expected 7", ppm); else passes++;
    checks++; if (ppm_avg !== 10'd1) $display("[TB] FAIL rearm_avg: got %0d expected 1", ppm_avg); else passes++;
    checks++; if (avg_ready !== 1'b0) $display("[TB] FAIL rearm_ready: got %0b expected 0", avg_ready); else passes++;
  endtask

  task automatic test_start_tick_same;
    applyPulses(4);
    start    = 1'b0;
    sec_tick = 1'b1;
    waitCycles(1);
    sec_tick = 1'b0;
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL same_cycle_valid: got %0b expected 0", ppm_valid); else passes++;
    checks++; if (ppm !== 10'd7) $display("[TB] FAIL same_cycle_ppm: got %0d expected 7", ppm); else passes++;
    waitCycles(1);
    checks++; if (ppm_valid !== 1'b0) $display("[TB] FAIL same_cycle_valid_late: got %0b expected 0", ppm_valid); else passes++;
  endtask

`ifdef PULSE_DEBOUNCE_EN
  task automatic test_debounce;
    start = 1'b1;
    waitCycles(1);
    applyTick();
    pulse_in = 1'b1;
    waitCycles(10);
    pulse_in = 1'b0;
    waitCycles(30);
    applyTick();
    checks++; if (ppm !== 10'd0) $display("[TB] FAIL glitch_ppm: got %0d expected 0", ppm); else passes++;
    pulse_in = 1'b1;
    waitCycles(20);
    pulse_in = 1'b0;
    waitCycles(30);
    applyTick();
    checks++; if (ppm !== 10'd1) $display("[TB] FAIL debounced_ppm: got %0d expected 1", ppm); else passes++;
  endtask
`endif

  // Scenario sequence
  initial begin
    checks   = 0;
    passes   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    sec_tick = 1'b0;
    pulse_in = 1'b0;
    test_reset();
    test_single_window();
    test_average();
    test_saturation();
    test_coincident();
    test_reset_mid_run();
    test_start_drop();
    test_start_tick_same();
`ifdef PULSE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
